sme_sched: RTL and testbench
============================

SME_SCHED -- requirements
Module: sme_sched

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one SME.
REQ-002 Parameter TIMEOUT, default 1024: WAIT-state cycle limit (used only with SME_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester char valid.
REQ-006 req_ready  output  NREQ  per-requester char accept.
REQ-007 req_char  input  8*NREQ  per-requester char, slice i = [8i+7:8i].
REQ-008 req_last  input  NREQ  marks final char of a job.
REQ-009 req_isstr  input  NREQ  1 = string job, 0 = pattern job; sampled with first char.
REQ-010 resp_valid  output  NREQ  one-cycle result pulse to job owner.
REQ-011 resp_match  output  1  match result; resp_index  output  5  match index; resp_err  output  1  error flag.
REQ-012 sme_chardata  output  8; sme_isstring  output  1; sme_ispattern  output  1: drive SME.
REQ-013 sme_valid  input  1; sme_match  input  1; sme_match_index  input  5: SME result.

Function
REQ-014 FSM states IDLE, COLLECT, BURST, WAIT, RESP; IDLE after reset.
REQ-015 IDLE: any req_valid -> round-robin grant registered, -> COLLECT next cycle; lowest index wins right after reset.
REQ-016 Round-robin: after a grant to i, requester i has lowest priority at next arbitration.
REQ-017 COLLECT: req_ready high only for owner; each valid&ready stores one char in local buffer; gaps allowed.
REQ-018 Buffer limit 32 chars (string) / 8 chars (pattern); excess chars accepted and dropped, length saturates.
REQ-019 req_last handshake -> BURST next cycle; non-owner req_ready stays 0 throughout.
REQ-020 BURST: buffer streamed one char per cycle, no gaps; sme_isstring (string) or sme_ispattern (pattern) high for exactly len cycles, first char 2 cycles after req_last handshake.
REQ-021 String job: after burst -> IDLE, string_loaded flag set, no response issued.
REQ-022 Pattern job with string_loaded=0: SME not driven; RESP with match=0, err=1.
REQ-023 Pattern job: after burst -> WAIT; first sme_valid in WAIT latched -> RESP.
REQ-024 sme_valid outside WAIT ignored.
REQ-025 RESP: resp_valid[owner] high one cycle, resp_match/resp_index/resp_err valid same cycle, err=0 on SME result; -> IDLE.
REQ-026 resp_index forced 0 when resp_match=0; result buses hold last value otherwise.
REQ-027 All outputs registered; sme_chardata 0 when not bursting.

Reset
REQ-028 reset low: state IDLE, req_ready=0, resp_valid=0, resp_match=0, resp_index=0, resp_err=0, sme_* outputs 0, string_loaded=0, RR pointer to NREQ-1, buffer length 0.
REQ-029 Reset mid-job discards job silently; no response issued after release.

Configuration
REQ-030 Macro SME_TIMEOUT_EN defined: WAIT cycle counter; reaching TIMEOUT -> RESP with match=0, err=1.
REQ-031 Macro undefined: no counter, WAIT waits indefinitely; resp_err set only by REQ-022.

Structure
REQ-032 Package sme_pkg: FSM state enum, MAX_STR=32, MAX_PAT=8, result struct {match, index[4:0], err}.
REQ-033 Sub-module sme_rr_arb: NREQ-wide round-robin arbiter, one-hot grant, pointer update on grant.

Verification
REQ-034 Req0 string "abcd" back-to-back -> sme_isstring high 4 consecutive cycles, chars a,b,c,d, no resp_valid.
REQ-035 Req1 pattern "bc" after string, SME model returns match=1 index=1 -> resp_valid[1] pulse, match=1, index=1, err=0.
REQ-036 Req0 and req1 both valid in IDLE twice -> grants 0 then 1; req_ready never high for both.
REQ-037 Pattern before any string -> resp_valid pulse with match=0, err=1, sme_ispattern never asserted.
REQ-038 40-char string with gaps in req_valid -> exactly 32 contiguous SME chars; pattern of 10 chars -> 8 SME chars.
REQ-039 SME_TIMEOUT_EN, TIMEOUT=16, model never asserts sme_valid -> resp_err=1 at cycle 16 of WAIT; reset low mid-COLLECT -> all outputs 0, no response.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared types and constants for the SME request scheduler.
// FSM states, buffer limits, result bundle, buffer-limit helper.
package sme_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_BURST,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int MAX_STR = 32;
  localparam int MAX_PAT = 8;

  typedef struct packed {
    logic       match;
    logic [4:0] index;
    logic       err;
  } sme_res_t;

  function automatic logic [5:0] buf_limit(input logic isstr);
    return isstr ? 6'(MAX_STR) : 6'(MAX_PAT);
  endfunction

endpackage

// File: rtl/sme_if.sv
// Requester, response and SME-side signal bundle for sme_sched.
// slave: scheduler side; master: requesters plus SME engine.
interface sme_if
  import sme_pkg::*;
#(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_char;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_isstr;
  logic [NREQ-1:0]   resp_valid;
  logic              resp_match;
  logic [4:0]        resp_index;
  logic              resp_err;
  logic [7:0]        sme_chardata;
  logic              sme_isstring;
  logic              sme_ispattern;
  logic              sme_valid;
  logic              sme_match;
  logic [4:0]        sme_match_index;

  modport slave (
    input  req_valid, req_char, req_last, req_isstr,
    input  sme_valid, sme_match, sme_match_index,
    output req_ready, resp_valid, resp_match, resp_index,
    output resp_err, sme_chardata, sme_isstring, sme_ispattern
  );

  modport master (
    output req_valid, req_char, req_last, req_isstr,
    output sme_valid, sme_match, sme_match_index,
    input  req_ready, resp_valid, resp_match, resp_index,
    input  resp_err, sme_chardata, sme_isstring, sme_ispattern
  );

endinterface

// File: rtl/sme_rr_arb.sv
// NREQ-wide round-robin arbiter, one-hot grant.
// Ports: clk, reset (async low), req, en (take grant), gnt.
module sme_rr_arb
  import sme_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] hi;

  // Requesters above the last winner go first; else wrap.
  always_comb begin
    mask = ~((NREQ'(2) << ptr_q) - NREQ'(1));
    hi   = req & mask;
    if (|hi) gnt = hi & (~hi + NREQ'(1));
    else     gnt = req & (~req + NREQ'(1));
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gidx = IW'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr_q <= IW'(NREQ - 1);
    else if (en && |req)
      ptr_q <= gidx;
  end

endmodule

// File: rtl/sme_sched.sv
// Shares one SME among NREQ requesters: collect, burst, wait, respond.
// Ports: clk, reset (async low), bus (sme_if.slave). Option: SME_TIMEOUT_EN.
module sme_sched
  import sme_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  sme_if.slave bus
);

  state_e          st_q, st_d;
  logic [NREQ-1:0] own_q, own_d, gnt;
  logic [NREQ-1:0] rdy_q, rdy_d, rv_q, rv_d;
  logic            isstr_q, isstr_d, cur_isstr;
  logic            loaded_q, loaded_d;
  logic [5:0]      len_q, len_d, bi_q, bi_d;
  sme_res_t        res_q, res_d, out_q, out_d;
  logic [7:0]      ch_q, ch_d;
  logic            is_q, is_d, ip_q, ip_d;
  logic            arb_en, wr_en, hs;
  logic [7:0]      own_ch;
  logic            own_v, own_last, own_isstr;
  logic [7:0]      buf_q [MAX_STR];

`ifdef SME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wc_q, wc_d;
`else
  // Without the timeout build, WAIT has no cycle limit.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  sme_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    own_ch    = '0;
    own_v     = 1'b0;
    own_last  = 1'b0;
    own_isstr = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (own_q[i]) begin
        own_ch    = bus.req_char[8*i +: 8];
        own_v     = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_isstr = bus.req_isstr[i];
      end
  end

  assign hs = own_v & (|rdy_q);

  always_comb begin
    st_d      = st_q;
    own_d     = own_q;
    isstr_d   = isstr_q;
    loaded_d  = loaded_q;
    len_d     = len_q;
    bi_d      = bi_q;
    res_d     = res_q;
    out_d     = out_q;
    rdy_d     = '0;
    rv_d      = '0;
    ch_d      = '0;
    is_d      = 1'b0;
    ip_d      = 1'b0;
    arb_en    = 1'b0;
    wr_en     = 1'b0;
    cur_isstr = isstr_q;
`ifdef SME_TIMEOUT_EN
    wc_d      = wc_q;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          arb_en = 1'b1;
          own_d  = gnt;
          rdy_d  = gnt;
          len_d  = '0;
          st_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        rdy_d = own_q;
        if (hs) begin
          // Job type comes with the first char only.
          cur_isstr = (len_q == 6'd0) ? own_isstr : isstr_q;
          isstr_d   = cur_isstr;
          if (len_q < buf_limit(cur_isstr)) begin
            wr_en = 1'b1;
            len_d = len_q + 6'd1;
          end
          if (own_last) begin
            rdy_d = '0;
            bi_d  = '0;
            st_d  = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (!isstr_q && !loaded_q) begin
          res_d = '{match: 1'b0, index: 5'd0, err: 1'b1};
          st_d  = S_RESP;
        end else begin
          ch_d = buf_q[bi_q[4:0]];
          is_d = isstr_q;
          ip_d = !isstr_q;
          bi_d = bi_q + 6'd1;
          if (bi_q == len_q - 6'd1) begin
            if (isstr_q) begin
              loaded_d = 1'b1;
              st_d     = S_IDLE;
            end else begin
              st_d = S_WAIT;
`ifdef SME_TIMEOUT_EN
              wc_d = '0;
`endif
            end
          end
        end
      end
      S_WAIT: begin
        if (bus.sme_valid) begin
          res_d = '{match: bus.sme_match,
                    index: bus.sme_match_index,
                    err:   1'b0};
          st_d  = S_RESP;
        end
`ifdef SME_TIMEOUT_EN
        else if (wc_q == TW'(TIMEOUT - 1)) begin
          res_d = '{match: 1'b0, index: 5'd0, err: 1'b1};
          st_d  = S_RESP;
        end else begin
          wc_d = wc_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        rv_d        = own_q;
        out_d.match = res_q.match;
        out_d.index = res_q.match ? res_q.index : 5'd0;
        out_d.err   = res_q.err;
        st_d        = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= S_IDLE;
      own_q    <= '0;
      rdy_q    <= '0;
      rv_q     <= '0;
      isstr_q  <= 1'b0;
      loaded_q <= 1'b0;
      len_q    <= '0;
      bi_q     <= '0;
      res_q    <= '0;
      out_q    <= '0;
      ch_q     <= '0;
      is_q     <= 1'b0;
      ip_q     <= 1'b0;
`ifdef SME_TIMEOUT_EN
      wc_q     <= '0;
`endif
    end else begin
      st_q     <= st_d;
      own_q    <= own_d;
      rdy_q    <= rdy_d;
      rv_q     <= rv_d;
      isstr_q  <= isstr_d;
      loaded_q <= loaded_d;
      len_q    <= len_d;
      bi_q     <= bi_d;
      res_q    <= res_d;
      out_q    <= out_d;
      ch_q     <= ch_d;
      is_q     <= is_d;
      ip_q     <= ip_d;
`ifdef SME_TIMEOUT_EN
      wc_q     <= wc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[len_q[4:0]] <= own_ch;
  end

  assign bus.req_ready     = rdy_q;
  assign bus.resp_valid    = rv_q;
  assign bus.resp_match    = out_q.match;
  assign bus.resp_index    = out_q.index;
  assign bus.resp_err      = out_q.err;
  assign bus.sme_chardata  = ch_q;
  assign bus.sme_isstring  = is_q;
  assign bus.sme_ispattern = ip_q;

endmodule

// File: tb/tb_sme_sched.sv
// Scoreboard bench for sme_sched: job-level reference model,
// SME engine model, randomized jobs plus directed corner cases.
module tb_sme_sched;

  localparam int NREQ = 2;
  localparam int TO   = 16;

  typedef byte unsigned bq_t[$];
  typedef struct {logic isstr; logic [7:0] ch;} exp_c_t;
  typedef struct {int owner; logic m; logic [4:0] idx; logic err;} exp_r_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sme_if #(.NREQ(NREQ)) bus();

  sme_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  exp_c_t exp_c[$];
  int     exp_len[$];
  exp_r_t exp_r[$];
  bq_t    m_str;
  bit     m_loaded = 0;
  int     m_last = NREQ - 1;
  int     grant_log[$];
  bit     sme_mute = 0;
  int     cyc = 0;
  int     run = 0;
  int     last_pat_cyc = 0;
  int     resp_cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  function automatic int find(bq_t s, bq_t p);
    bit ok;
    for (int i = 0; i + p.size() <= s.size(); i++) begin
      ok = 1;
      for (int j = 0; j < p.size(); j++)
        if (s[i+j] != p[j]) ok = 0;
      if (ok) return i;
    end
    return -1;
  endfunction

  function automatic bq_t mk(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Job-level reference: what the SME must see and what comes back.
  function automatic void model_job(int r, bit isstr, bq_t cs);
    bq_t eff;
    int lim;
    int k;
    lim = isstr ? 32 : 8;
    for (int i = 0; i < cs.size() && i < lim; i++) eff.push_back(cs[i]);
    m_last = r;
    grant_log.push_back(r);
    if (!isstr && !m_loaded) begin
      exp_r.push_back('{r, 1'b0, 5'd0, 1'b1});
    end else begin
      foreach (eff[i]) exp_c.push_back('{isstr, eff[i]});
      exp_len.push_back(eff.size());
      if (isstr) begin
        m_str = eff;
        m_loaded = 1;
      end else if (sme_mute) begin
        exp_r.push_back('{r, 1'b0, 5'd0, 1'b1});
      end else begin
        k = find(m_str, eff);
        exp_r.push_back('{r, k >= 0, (k >= 0) ? 5'(k) : 5'd0, 1'b0});
      end
    end
  endfunction

  task automatic send(int r, bit isstr, bq_t cs, int gap_pct);
    int i;
    int budget;
    logic rdy;
    i = 0;
    budget = 0;
    while (i < cs.size()) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.req_valid[r] = 1'b0;
      end else begin
        bus.req_valid[r] = 1'b1;
        bus.req_char[8*r +: 8] = cs[i];
        bus.req_last[r] = (i == cs.size() - 1);
        bus.req_isstr[r] = isstr;
      end
      @(negedge clk);
      rdy = bus.req_ready[r];
      @(posedge clk);
      #1;
      if (rdy && bus.req_valid[r]) begin
        if (i == cs.size() - 1) model_job(r, isstr, cs);
        i++;
      end
      budget++;
      if (budget > 3000) begin
        chk("send_timeout", 64'(budget), 64'(0));
        break;
      end
    end
    bus.req_valid[r] = 1'b0;
    bus.req_last[r] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_c.size() || exp_len.size() || exp_r.size()) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_c.size() + exp_len.size() + exp_r.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rvalid"}, 64'(bus.resp_valid), 64'(0));
    chk({tag, "_rmatch"}, 64'(bus.resp_match), 64'(0));
    chk({tag, "_rindex"}, 64'(bus.resp_index), 64'(0));
    chk({tag, "_rerr"}, 64'(bus.resp_err), 64'(0));
    chk({tag, "_schar"}, 64'(bus.sme_chardata), 64'(0));
    chk({tag, "_sstr"}, 64'(bus.sme_isstring), 64'(0));
    chk({tag, "_spat"}, 64'(bus.sme_ispattern), 64'(0));
  endtask

  // Monitor / scoreboard.
  exp_c_t ec;
  exp_r_t er;
  logic [NREQ-1:0] ev;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      run = 0;
    end else begin
      if (bus.sme_isstring || bus.sme_ispattern) begin
        if (bus.sme_ispattern) last_pat_cyc = cyc;
        if (exp_c.size() == 0) begin
          chk("sme_unexpected", 64'(bus.sme_chardata), 64'hff00);
        end else begin
          ec = exp_c.pop_front();
          chk("sme_char", 64'(bus.sme_chardata), 64'(ec.ch));
          chk("sme_kind", {bus.sme_isstring, bus.sme_ispattern},
              {ec.isstr, ~ec.isstr});
        end
        run++;
      end else begin
        chk("sme_idle_data", 64'(bus.sme_chardata), 64'(0));
        if (run > 0) begin
          if (exp_len.size() == 0) chk("burst_unexpected", 64'(run), 64'(0));
          else chk("burst_len", 64'(run), 64'(exp_len.pop_front()));
          run = 0;
        end
      end
      chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
      if (|bus.resp_valid) begin
        resp_cyc = cyc;
        if (exp_r.size() == 0) begin
          chk("resp_unexpected", 64'(bus.resp_valid), 64'(0));
        end else begin
          er = exp_r.pop_front();
          ev = '0;
          ev[er.owner] = 1'b1;
          chk("resp_owner", 64'(bus.resp_valid), 64'(ev));
          chk("resp_match", 64'(bus.resp_match), 64'(er.m));
          chk("resp_index", 64'(bus.resp_index), 64'(er.idx));
          chk("resp_err", 64'(bus.resp_err), 64'(er.err));
        end
      end
    end
  end

  // SME engine model: remembers the last string, answers patterns.
  bq_t s_str;
  bq_t s_pat;
  bit  s_pstr = 0;
  bit  s_ppat = 0;
  int  pend = -1;
  int  sk;
  initial begin
    bus.sme_valid = 1'b0;
    bus.sme_match = 1'b0;
    bus.sme_match_index = 5'd0;
    forever begin
      @(negedge clk);
      bus.sme_valid = 1'b0;
      if (!reset) begin
        pend = -1;
        s_pstr = 0;
        s_ppat = 0;
      end else begin
        if (bus.sme_isstring) begin
          if (!s_pstr) s_str.delete();
          s_str.push_back(bus.sme_chardata);
          // Stray results while no pattern is pending must be ignored.
          if ($urandom_range(3) == 0) begin
            bus.sme_valid = 1'b1;
            bus.sme_match = 1'b1;
            bus.sme_match_index = 5'd31;
          end
        end
        if (bus.sme_ispattern) begin
          if (!s_ppat) s_pat.delete();
          s_pat.push_back(bus.sme_chardata);
        end else if (s_ppat && !sme_mute) begin
          pend = $urandom_range(4);
        end
        if (pend == 0) begin
          sk = find(s_str, s_pat);
          bus.sme_valid = 1'b1;
          bus.sme_match = (sk >= 0);
          bus.sme_match_index = (sk >= 0) ? 5'(sk) : 5'($urandom);
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        s_pstr = bus.sme_isstring;
        s_ppat = bus.sme_ispattern;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=%0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t a;
    bq_t b;
    int first;
    bus.req_valid = '0;
    bus.req_char = '0;
    bus.req_last = '0;
    bus.req_isstr = '0;
    #12;
    chk_reset_outs("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Two concurrent rounds: string on 0, pattern on 1.
    for (int round = 0; round < 2; round++) begin
      if (round == 0) begin
        a = mk("abcd");
        b = mk("bc");
      end else begin
        a.delete();
        b.delete();
        repeat ($urandom_range(3, 10)) a.push_back(8'($urandom_range(97, 99)));
        repeat ($urandom_range(1, 3)) b.push_back(8'($urandom_range(97, 99)));
      end
      first = (m_last + 1) % NREQ;
      grant_log.delete();
      fork
        send(0, 1'b1, a, 0);
        send(1, 1'b0, b, (round == 0) ? 0 : 30);
      join
      wait_drain();
      chk("grant_first", 64'(grant_log[0]), 64'(first));
      chk("grant_second", 64'(grant_log[1]), 64'(1 - first));
    end

    // Fresh reset: pattern before any string.
    @(negedge clk);
    reset = 1'b0;
    m_loaded = 0;
    m_str.delete();
    m_last = NREQ - 1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(1, 1'b0, mk("ab"), 0);
    wait_drain();

    // Saturation: 40-char string with gaps, 10-char pattern.
    a.delete();
    for (int i = 0; i < 40; i++) a.push_back(8'(97 + (i % 5)));
    send(0, 1'b1, a, 40);
    send(1, 1'b0, mk("abcdeabcde"), 20);
    wait_drain();

    // Randomized jobs.
    for (int n = 0; n < 24; n++) begin
      int r;
      bit s;
      int len;
      a.delete();
      r = $urandom_range(NREQ - 1);
      s = 1'($urandom_range(1));
      len = s ? $urandom_range(1, 40) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) a.push_back(8'($urandom_range(97, 99)));
      send(r, s, a, $urandom_range(40));
    end
    wait_drain();

    // Reset in the middle of collecting a job.
    bus.req_valid[0] = 1'b1;
    bus.req_isstr[0] = 1'b1;
    bus.req_char[7:0] = 8'h78;
    bus.req_last[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    bus.req_valid = '0;
    m_loaded = 0;
    m_str.delete();
    m_last = NREQ - 1;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;
    send(1, 1'b0, mk("x"), 0);
    wait_drain();

`ifdef SME_TIMEOUT_EN
    send(0, 1'b1, mk("abcabc"), 0);
    wait_drain();
    sme_mute = 1;
    send(1, 1'b0, mk("ca"), 0);
    wait_drain();
    chk("timeout_lo", 64'(resp_cyc - last_pat_cyc >= TO), 64'(1));
    chk("timeout_hi", 64'(resp_cyc - last_pat_cyc <= TO + 2), 64'(1));
    sme_mute = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
